// File: rtl/uart_pkg.sv
// uart_pkg: shared state type, frame constants and bit-timing helper for the UART blocks.
package uart_pkg;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned STOP_BITS = 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    // One bit period spans two half-bit intervals of the shared io timing.
    function automatic int unsigned clk_per_bit(input int unsigned half_bit);
        return 2 * half_bit;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous byte FIFO with a combinational head read and a registered occupancy count.
module uart_tx_fifo #(
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [7:0]                    wdata,
    input  logic                          we,
    output logic                          full,
    output logic [7:0]                    rdata,
    input  logic                          re,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_wr;
    logic          do_rd;

    assign full  = (count == (AW+1)'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign rdata = mem[rptr];
    assign do_wr = we && !full;
    assign do_rd = re && !empty;

    // Storage write; entries need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wptr] <= wdata;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks net push/pop.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_wr) begin
                wptr <= wptr + AW'(1);
            end
            if (do_rd) begin
                rptr <= rptr + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_buf.sv
// uart_tx_buf: buffered UART transmitter, 8N1 LSB-first, FIFO-fed over a valid/ready handshake.
// Optional even parity bit after the data bits when UART_TX_PARITY_EN is defined.
module uart_tx_buf #(
    parameter int unsigned CLK_PER_HALF_BIT = 4,
    parameter int unsigned FIFO_DEPTH       = 16
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [7:0]                    tdata,
    input  logic                          tdata_valid,
    output logic                          tdata_ready,
    output logic                          txd,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    import uart_pkg::*;

    localparam int unsigned CLK_PER_BIT = clk_per_bit(CLK_PER_HALF_BIT);
    localparam int unsigned CW          = $clog2(CLK_PER_BIT);
    localparam int unsigned BW          = $clog2(DATA_BITS);

    tx_state_t          state;
    logic [CW-1:0]      cnt;
    logic [BW-1:0]      bit_idx;
    logic [7:0]         sh;
    logic [7:0]         fifo_rdata;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_re;
    logic               bit_end;
`ifdef UART_TX_PARITY_EN
    logic               par_bit;
`endif

    assign tdata_ready = !fifo_full;
    assign bit_end     = (cnt == CW'(CLK_PER_BIT - 1));
    // Pop from IDLE, or at the end of a stop bit to chain frames without a gap.
    assign fifo_re     = !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_end));

    uart_tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .wdata (tdata),
        .we    (tdata_valid),
        .full  (fifo_full),
        .rdata (fifo_rdata),
        .re    (fifo_re),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // busy reflects last cycle's state/occupancy, so it drops one edge after the final stop bit.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            busy <= 1'b0;
        end else begin
            busy <= (state != IDLE) || (fifo_count != '0);
        end
    end

    // Frame sequencer: bit timing, shift register and the registered serial line.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            sh      <= '0;
            txd     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_bit <= 1'b0;
`endif
        end else begin
            if (state != IDLE) begin
                cnt <= bit_end ? '0 : cnt + CW'(1);
            end
            case (state)
                IDLE: begin
                    if (fifo_re) begin
                        sh    <= fifo_rdata;
`ifdef UART_TX_PARITY_EN
                        par_bit <= ^fifo_rdata;
`endif
                        txd   <= 1'b0;
                        cnt   <= '0;
                        state <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        txd     <= sh[0];
                        bit_idx <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx == BW'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                            txd   <= par_bit;
                            state <= PARITY;
`else
                            txd   <= 1'b1;
                            state <= STOP;
`endif
                        end else begin
                            sh      <= sh >> 1;
                            txd     <= sh[1];
                            bit_idx <= bit_idx + BW'(1);
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        txd   <= 1'b1;
                        state <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        if (fifo_re) begin
                            sh    <= fifo_rdata;
`ifdef UART_TX_PARITY_EN
                            par_bit <= ^fifo_rdata;
`endif
                            txd   <= 1'b0;
                            state <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    txd   <= 1'b1;
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_buf.sv
// tb_uart_tx_buf: directed, table-driven bench for uart_tx_buf with a loopback frame decoder.
module tb_uart_tx_buf;

    localparam int unsigned HALF  = 4;
    localparam int unsigned CPB   = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned CNTW  = $clog2(DEPTH) + 1;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned NBITS = 11;
`else
    localparam int unsigned NBITS = 10;
`endif
    localparam int unsigned FRAME = NBITS * CPB;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic [7:0]      tdata = 8'h00;
    logic            tdata_valid = 1'b0;
    logic            tdata_ready;
    logic            txd;
    logic            busy;
    logic [CNTW-1:0] fifo_count;

    int n_chk  = 0;
    int n_fail = 0;

    // line[j] is the expected txd level during bit period j of an 8N1 frame (start at j=0, stop at j=9).
    typedef struct {
        string      name;
        logic [7:0] data;
        logic [9:0] line;
        logic       par;
    } vec_t;

    typedef struct packed {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } rx_t;

    vec_t vt[7];
    rx_t  rx_q[$];

    uart_tx_buf #(
        .CLK_PER_HALF_BIT (HALF),
        .FIFO_DEPTH       (DEPTH)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .tdata       (tdata),
        .tdata_valid (tdata_valid),
        .tdata_ready (tdata_ready),
        .txd         (txd),
        .busy        (busy),
        .fifo_count  (fifo_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Loopback receiver: sample mid-bit on the falling edge, queue each decoded frame.
    logic       rx_act = 1'b0;
    int         rx_ph  = 0;
    logic [7:0] rx_sh  = 8'h00;
    logic       rx_par = 1'b0;
    always @(negedge clk) begin
        int j;
        if (!rstn) begin
            rx_act = 1'b0;
        end else if (!rx_act) begin
            if (txd === 1'b0) begin
                rx_act = 1'b1;
                rx_ph  = 0;
            end
        end else begin
            rx_ph = rx_ph + 1;
            if ((rx_ph % CPB) == CPB / 2) begin
                j = rx_ph / CPB;
                if (j == NBITS - 1) begin
`ifdef UART_TX_PARITY_EN
                    rx_q.push_back('{rx_sh, txd !== 1'b1, rx_par !== (^rx_sh)});
`else
                    rx_q.push_back('{rx_sh, txd !== 1'b1, 1'b0});
`endif
                    rx_act = 1'b0;
                end else if (j >= 1 && j <= 8) begin
                    rx_sh[3'(j - 1)] = txd;
                end else if (j == 9) begin
                    rx_par = txd;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tdata_valid = 1'b0;
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        rx_q.delete();
    endtask

    task automatic push_one(input logic [7:0] d);
        tdata       = d;
        tdata_valid = 1'b1;
        tick();
        tdata_valid = 1'b0;
    endtask

    function automatic logic exp_bit(input vec_t v, input int j);
`ifdef UART_TX_PARITY_EN
        if (j < 9) return v.line[j];
        if (j == 9) return v.par;
        return v.line[9];
`else
        return v.line[j];
`endif
    endfunction

    // Checks every sample of each bit period; entered on the first unchecked sample of bit 0.
    // Optionally presents a byte so that it is accepted on the edge that ends the stop bit.
    task automatic check_frame(input vec_t v, input int skip, input bit push_last, input logic [7:0] pd);
        int   ns;
        int   nmatch;
        logic e;
        for (int j = 0; j < int'(NBITS); j++) begin
            e      = exp_bit(v, j);
            ns     = (j == 0) ? int'(CPB) - skip : int'(CPB);
            nmatch = 0;
            for (int s = 0; s < ns; s++) begin
                if (txd === e) nmatch++;
                if (push_last && j == int'(NBITS) - 1 && s == ns - 1) begin
                    tdata       = pd;
                    tdata_valid = 1'b1;
                end
                tick();
            end
            check($sformatf("frame %s bit%0d samples", v.name, j), 32'(nmatch), 32'(ns));
        end
    endtask

    task automatic expect_rx(input string name, input logic [7:0] exp, input int budget);
        int  w;
        rx_t r;
        w = 0;
        while (rx_q.size() == 0 && w < budget) begin
            tick();
            w++;
        end
        if (rx_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL rx %s: timeout, got no frame, expected 0x%02h", name, exp);
        end else begin
            r = rx_q.pop_front();
            check($sformatf("rx %s data", name), 32'(r.data), 32'(exp));
            check($sformatf("rx %s ferr", name), 32'(r.ferr), 32'd0);
`ifdef UART_TX_PARITY_EN
            check($sformatf("rx %s perr", name), 32'(r.perr), 32'd0);
`endif
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int w;
        w = 0;
        while (busy && w < budget) begin
            tick();
            w++;
        end
        check($sformatf("%s idle", name), 32'(busy), 32'd0);
    endtask

    initial begin
        int acc;
        int nhigh;

        vt[0] = '{"A5", 8'hA5, 10'b1101001010, 1'b0};
        vt[1] = '{"00", 8'h00, 10'b1000000000, 1'b0};
        vt[2] = '{"FF", 8'hFF, 10'b1111111110, 1'b0};
        vt[3] = '{"55", 8'h55, 10'b1010101010, 1'b0};
        vt[4] = '{"3C", 8'h3C, 10'b1001111000, 1'b0};
        vt[5] = '{"07", 8'h07, 10'b1000001110, 1'b1};
        vt[6] = '{"03", 8'h03, 10'b1000000110, 1'b0};

        // Single-byte frames from reset: latency, bit timing, frame length, busy fall.
        for (int i = 0; i < 7; i++) begin
            do_reset();
            check("reset txd", 32'(txd), 32'd1);
            check("reset busy", 32'(busy), 32'd0);
            check("reset count", 32'(fifo_count), 32'd0);
            check("reset ready", 32'(tdata_ready), 32'd1);
            push_one(vt[i].data);
            check($sformatf("%s accept count", vt[i].name), 32'(fifo_count), 32'd1);
            check($sformatf("%s accept txd", vt[i].name), 32'(txd), 32'd1);
            tick();
            check($sformatf("%s pop count", vt[i].name), 32'(fifo_count), 32'd0);
            check($sformatf("%s pop busy", vt[i].name), 32'(busy), 32'd1);
            check_frame(vt[i], 0, 1'b0, 8'h00);
            check($sformatf("%s busy at stop end", vt[i].name), 32'(busy), 32'd1);
            tick();
            check($sformatf("%s busy after frame", vt[i].name), 32'(busy), 32'd0);
            check($sformatf("%s txd idle", vt[i].name), 32'(txd), 32'd1);
            expect_rx(vt[i].name, vt[i].data, 10);
        end

        // Three pushes on consecutive cycles: back-to-back frames, occupancy peaks at 2.
        do_reset();
        tdata = 8'h00; tdata_valid = 1'b1;
        tick();
        check("b2b count after push0", 32'(fifo_count), 32'd1);
        tdata = 8'hFF;
        tick();
        check("b2b count push1+pop0", 32'(fifo_count), 32'd1);
        tdata = 8'h55;
        tick();
        tdata_valid = 1'b0;
        check("b2b count peak", 32'(fifo_count), 32'd2);
        check_frame(vt[1], 1, 1'b0, 8'h00);
        check("b2b count after frame0", 32'(fifo_count), 32'd1);
        check_frame(vt[2], 0, 1'b0, 8'h00);
        check("b2b count after frame1", 32'(fifo_count), 32'd0);
        check_frame(vt[3], 0, 1'b0, 8'h00);
        tick();
        check("b2b busy after frames", 32'(busy), 32'd0);
        expect_rx("b2b 0", 8'h00, 10);
        expect_rx("b2b 1", 8'hFF, 10);
        expect_rx("b2b 2", 8'h55, 10);

        // Continuous offer for 20 cycles: 17 accepted, then backpressure; all delivered in order.
        do_reset();
        acc = 0;
        for (int k = 0; k < 20; k++) begin
            tdata       = 8'(k);
            tdata_valid = 1'b1;
            if (tdata_ready) acc++;
            tick();
        end
        tdata_valid = 1'b0;
        check("fill accepted", 32'(acc), 32'd17);
        check("fill ready low", 32'(tdata_ready), 32'd0);
        check("fill count full", 32'(fifo_count), 32'd16);
        for (int k = 0; k < 17; k++) begin
            expect_rx($sformatf("fill %0d", k), 8'(k), int'(FRAME) * 2 + 20);
        end
        wait_idle("fill", int'(FRAME) + 20);
        check("fill no extra frames", 32'(rx_q.size()), 32'd0);

        // One-clock reset in data bit 3 aborts the frame and drops queued bytes.
        do_reset();
        tdata = 8'hA5; tdata_valid = 1'b1;
        tick();
        tdata = 8'hFF;
        tick();
        tdata = 8'h00;
        tick();
        tdata_valid = 1'b0;
        repeat (34) tick();
        check("abort pre-reset bit3", 32'(txd), 32'd0);
        check("abort pre-reset count", 32'(fifo_count), 32'd2);
        rstn = 1'b0;
        tick();
        check("abort txd", 32'(txd), 32'd1);
        check("abort count", 32'(fifo_count), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort ready", 32'(tdata_ready), 32'd1);
        rstn = 1'b1;
        nhigh = 0;
        for (int k = 0; k < 100; k++) begin
            if (txd === 1'b1) nhigh++;
            tick();
        end
        check("abort line stays idle", 32'(nhigh), 32'd100);
        check("abort no frames", 32'(rx_q.size()), 32'd0);
        push_one(8'h3C);
        tick();
        check_frame(vt[4], 0, 1'b0, 8'h00);
        expect_rx("after abort", 8'h3C, 10);

        // Byte accepted on the stop-end edge with an empty FIFO: full stop bit, then start one edge later.
        do_reset();
        push_one(8'hA5);
        tick();
        check_frame(vt[0], 0, 1'b1, 8'h3C);
        tdata_valid = 1'b0;
        check("late push txd still stop", 32'(txd), 32'd1);
        check("late push count", 32'(fifo_count), 32'd1);
        check("late push busy", 32'(busy), 32'd1);
        tick();
        check("late push start txd", 32'(txd), 32'd0);
        check("late push popped", 32'(fifo_count), 32'd0);
        check_frame(vt[4], 0, 1'b0, 8'h00);
        tick();
        check("late push busy after", 32'(busy), 32'd0);
        expect_rx("late 0", 8'hA5, 10);
        expect_rx("late 1", 8'h3C, 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
